// File: rtl/signed_mac_accum.sv
// Signed multiply-accumulate: sums COUNT signed products into one ACC_W-bit result behind valid/ready.
// Build option: MAC_SATURATE_EN clamps the accumulator on overflow; when it is undefined the sum wraps.
module signed_mac_accum #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned ACC_W = 24,
  parameter int unsigned COUNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_a,
  input  logic [IN_W-1:0]  in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_overflow
);

  localparam int unsigned P_W   = 2 * IN_W;
  localparam int unsigned S_W   = ACC_W + 1;
  localparam int unsigned CNT_W = $clog2(COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(COUNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

  typedef enum logic {ST_ACCUM, ST_HOLD} state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [P_W-1:0]   p_q, p_d;
  logic                    p_v_q, p_v_d;
  logic                    p_first_q, p_first_d;
  logic                    p_last_q, p_last_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic                    ovf_acc_q, ovf_acc_d;
  logic                    out_valid_q, out_valid_d;
  logic [ACC_W-1:0]        out_sum_q, out_sum_d;
  logic                    out_overflow_q, out_overflow_d;

  logic                    accept;
  logic signed [P_W-1:0]   a_ext, b_ext;
  logic signed [S_W-1:0]   p_ext, base, sum;
  logic                    step_ovf;
  logic [ACC_W-1:0]        acc_step;

  assign in_ready     = (state_q == ST_ACCUM) && (cnt_q < CNT_MAX) && !rst;
  assign accept       = in_valid && in_ready;
  assign out_valid    = out_valid_q;
  assign out_sum      = out_sum_q;
  assign out_overflow = out_overflow_q;

  // Accumulate one extra bit wide so a sign disagreement flags overflow.
  always_comb begin
    a_ext    = P_W'($signed(in_a));
    b_ext    = P_W'($signed(in_b));
    p_ext    = {{(S_W - P_W){p_q[P_W-1]}}, p_q};
    base     = p_first_q ? '0 : {acc_q[ACC_W-1], acc_q};
    sum      = base + p_ext;
    step_ovf = p_v_q && (sum[ACC_W] != sum[ACC_W-1]);
    acc_step = sum[ACC_W-1:0];
`ifdef MAC_SATURATE_EN
    if (step_ovf) begin
      acc_step = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
`endif
  end

  // Next-state: product stage, accumulate stage and result handshake.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    p_d            = p_q;
    p_v_d          = 1'b0;
    p_first_d      = p_first_q;
    p_last_d       = p_last_q;
    acc_d          = acc_q;
    ovf_acc_d      = ovf_acc_q;
    out_valid_d    = out_valid_q;
    out_sum_d      = out_sum_q;
    out_overflow_d = out_overflow_q;

    if (accept) begin
      p_d       = a_ext * b_ext;
      p_v_d     = 1'b1;
      p_first_d = (cnt_q == '0);
      p_last_d  = (cnt_q == CNT_LAST);
      cnt_d     = cnt_q + CNT_W'(1);
    end

    if (p_v_q) begin
      acc_d     = acc_step;
      ovf_acc_d = (p_first_q ? 1'b0 : ovf_acc_q) | step_ovf;
      if (p_last_q) begin
        out_sum_d      = acc_step;
        out_overflow_d = ovf_acc_d;
        out_valid_d    = 1'b1;
        state_d        = ST_HOLD;
      end
    end

    if ((state_q == ST_HOLD) && out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      cnt_d       = '0;
      state_d     = ST_ACCUM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_ACCUM;
      cnt_q          <= '0;
      p_q            <= '0;
      p_v_q          <= 1'b0;
      p_first_q      <= 1'b0;
      p_last_q       <= 1'b0;
      acc_q          <= '0;
      ovf_acc_q      <= 1'b0;
      out_valid_q    <= 1'b0;
      out_sum_q      <= '0;
      out_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      p_q            <= p_d;
      p_v_q          <= p_v_d;
      p_first_q      <= p_first_d;
      p_last_q       <= p_last_d;
      acc_q          <= acc_d;
      ovf_acc_q      <= ovf_acc_d;
      out_valid_q    <= out_valid_d;
      out_sum_q      <= out_sum_d;
      out_overflow_q <= out_overflow_d;
    end
  end

endmodule

// File: tb/tb_signed_mac_accum.sv
// Testbench for signed_mac_accum: directed scenarios on three configurations plus a randomized run
// against an arithmetic reference model.
module tb_signed_mac_accum;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // dut_a: defaults (ACC_W=24, COUNT=4)
  logic v0, r0, ov0, ordy0, of0;
  logic [7:0] a0, b0;
  logic [23:0] s0;
  // dut_b: ACC_W=16 for overflow behaviour
  logic v1, r1, ov1, ordy1, of1;
  logic [7:0] a1, b1;
  logic [15:0] s1;
  // dut_c: COUNT=1
  logic v2, r2, ov2, ordy2, of2;
  logic [7:0] a2, b2;
  logic [23:0] s2;

  int n_pass = 0;
  int n_total = 0;

  signed_mac_accum dut_a (
    .clk(clk), .rst(rst), .in_valid(v0), .in_ready(r0), .in_a(a0), .in_b(b0),
    .out_valid(ov0), .out_ready(ordy0), .out_sum(s0), .out_overflow(of0));

  signed_mac_accum #(.ACC_W(16)) dut_b (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1), .in_a(a1), .in_b(b1),
    .out_valid(ov1), .out_ready(ordy1), .out_sum(s1), .out_overflow(of1));

  signed_mac_accum #(.COUNT(1)) dut_c (
    .clk(clk), .rst(rst), .in_valid(v2), .in_ready(r2), .in_a(a2), .in_b(b2),
    .out_valid(ov2), .out_ready(ordy2), .out_sum(s2), .out_overflow(of2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fit an exact integer sum into w signed bits, reporting whether it was out of range.
  function automatic longint fit(input longint s, input int w, output bit ovf);
    longint mx, mn, r;
    mx  = (longint'(1) <<< (w - 1)) - 1;
    mn  = -mx - 1;
    ovf = (s > mx) || (s < mn);
    r   = s;
`ifdef MAC_SATURATE_EN
    if (s > mx) r = mx;
    else if (s < mn) r = mn;
`else
    r = s & ((longint'(1) <<< w) - 1);
    if (r > mx) r = r - (longint'(1) <<< w);
`endif
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1; v0 = 1'b1;
    tick(); tick();
    n_total++; if (ov0 !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", ov0); else n_pass++;
    n_total++; if (s0 !== 24'd0) $display("FAIL reset_out_sum got=%0d want=0", s0); else n_pass++;
    n_total++; if (of0 !== 1'b0) $display("FAIL reset_out_overflow got=%b want=0", of0); else n_pass++;
    n_total++; if ({r0, r1, r2} !== 3'b000) $display("FAIL reset_in_ready got=%b want=000", {r0, r1, r2}); else n_pass++;
    v0 = 1'b0; rst = 1'b0; #1;
    n_total++; if (r0 !== 1'b1) $display("FAIL post_reset_in_ready got=%b want=1", r0); else n_pass++;
  endtask

  task automatic test_basic();
    int ta[4] = '{3, -2, 127, -128};
    int tb[4] = '{4, 5, 127, 1};
    ordy0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a0 = 8'(ta[i]); b0 = 8'(tb[i]); v0 = 1'b1;
      n_total++; if (r0 !== 1'b1) $display("FAIL basic_in_ready[%0d] got=%b want=1", i, r0); else n_pass++;
      tick();
    end
    v0 = 1'b0;
    n_total++; if (ov0 !== 1'b0) $display("FAIL basic_early_valid got=%b want=0", ov0); else n_pass++;
    tick();
    n_total++; if (ov0 !== 1'b1) $display("FAIL basic_out_valid got=%b want=1", ov0); else n_pass++;
    n_total++; if (s0 !== 24'd16003) $display("FAIL basic_out_sum got=%0d want=16003", $signed(s0)); else n_pass++;
    n_total++; if (of0 !== 1'b0) $display("FAIL basic_overflow got=%b want=0", of0); else n_pass++;
    tick();
    n_total++; if (ov0 !== 1'b0) $display("FAIL basic_single_pulse got=%b want=0", ov0); else n_pass++;
  endtask

  task automatic test_backpressure();
    int ta[4] = '{3, -2, 127, -128};
    int tb[4] = '{4, 5, 127, 1};
    ordy0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a0 = 8'(ta[i]); b0 = 8'(tb[i]); v0 = 1'b1;
      tick();
    end
    v0 = 1'b0;
    tick(); tick();
    v0 = 1'b1; a0 = 8'd5; b0 = 8'd5;
    for (int i = 0; i < 5; i++) begin
      n_total++;
      if (r0 !== 1'b0 || ov0 !== 1'b1 || s0 !== 24'd16003)
        $display("FAIL bp_hold[%0d] got ready=%b valid=%b sum=%0d want ready=0 valid=1 sum=16003",
                 i, r0, ov0, $signed(s0));
      else n_pass++;
      tick();
    end
    ordy0 = 1'b1;
    tick();
    n_total++;
    if (ov0 !== 1'b0 || r0 !== 1'b1 || s0 !== 24'd16003)
      $display("FAIL bp_release got valid=%b ready=%b sum=%0d want valid=0 ready=1 sum=16003", ov0, r0, $signed(s0));
    else n_pass++;
    v0 = 1'b0;
  endtask

  task automatic test_gaps();
    bit pat[9] = '{1, 0, 0, 0, 1, 0, 1, 0, 1};
    int pulses = 0;
    logic [23:0] got = '0;
    ordy0 = 1'b1; a0 = 8'd2; b0 = 8'd2;
    for (int i = 0; i < 9; i++) begin
      v0 = pat[i];
      if (ov0) begin pulses++; got = s0; end
      tick();
    end
    v0 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (ov0) begin pulses++; got = s0; end
      tick();
    end
    n_total++; if (pulses != 1) $display("FAIL gaps_pulses got=%0d want=1", pulses); else n_pass++;
    n_total++; if (got !== 24'd16) $display("FAIL gaps_sum got=%0d want=16", $signed(got)); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    logic [23:0] got = '0;
    ordy0 = 1'b1; a0 = 8'd10; b0 = 8'd10; v0 = 1'b1;
    tick(); tick();
    v0 = 1'b0; rst = 1'b1;
    tick();
    n_total++;
    if (ov0 !== 1'b0 || r0 !== 1'b0) $display("FAIL midrst_during got valid=%b ready=%b want 0 0", ov0, r0);
    else n_pass++;
    rst = 1'b0; #1;
    n_total++; if (ov0 !== 1'b0) $display("FAIL midrst_after got valid=%b want=0", ov0); else n_pass++;
    a0 = 8'd1; b0 = 8'(-1);
    for (int i = 0; i < 10; i++) begin
      v0 = (i < 4);
      if (ov0) begin pulses++; got = s0; end
      tick();
    end
    v0 = 1'b0;
    n_total++; if (pulses != 1) $display("FAIL midrst_pulses got=%0d want=1", pulses); else n_pass++;
    n_total++; if (got !== 24'(-4)) $display("FAIL midrst_sum got=%0d want=-4", $signed(got)); else n_pass++;
  endtask

  task automatic test_overflow();
    int pulses = 0;
    logic [15:0] got = '0;
    logic gov = 1'b0;
`ifdef MAC_SATURATE_EN
    logic [15:0] want = 16'd32767;
`else
    logic [15:0] want = 16'd0;
`endif
    ordy1 = 1'b1; a1 = 8'(-128); b1 = 8'(-128);
    for (int i = 0; i < 10; i++) begin
      v1 = (i < 4);
      if (ov1) begin pulses++; got = s1; gov = of1; end
      tick();
    end
    n_total++; if (pulses != 1) $display("FAIL ovf_pulses got=%0d want=1", pulses); else n_pass++;
    n_total++; if (got !== want) $display("FAIL ovf_sum got=%0d want=%0d", $signed(got), $signed(want)); else n_pass++;
    n_total++; if (gov !== 1'b1) $display("FAIL ovf_flag got=%b want=1", gov); else n_pass++;
    a1 = 8'd1; b1 = 8'd1; pulses = 0;
    for (int i = 0; i < 10; i++) begin
      v1 = (i < 4);
      if (ov1) begin pulses++; got = s1; gov = of1; end
      tick();
    end
    v1 = 1'b0;
    n_total++;
    if (pulses != 1 || got !== 16'd4 || gov !== 1'b0)
      $display("FAIL ovf_next got pulses=%0d sum=%0d ovf=%b want 1 4 0", pulses, $signed(got), gov);
    else n_pass++;
  endtask

  task automatic test_count1();
    int ta[2] = '{-128, 5};
    int tb[2] = '{127, 5};
    int ws[2] = '{-16256, 25};
    ordy2 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a2 = 8'(ta[i]); b2 = 8'(tb[i]); v2 = 1'b1;
      n_total++; if (r2 !== 1'b1) $display("FAIL c1_in_ready[%0d] got=%b want=1", i, r2); else n_pass++;
      tick();
      v2 = 1'b0;
      n_total++; if (ov2 !== 1'b0) $display("FAIL c1_early[%0d] got=%b want=0", i, ov2); else n_pass++;
      tick();
      n_total++;
      if (ov2 !== 1'b1 || s2 !== 24'(ws[i]))
        $display("FAIL c1_result[%0d] got valid=%b sum=%0d want valid=1 sum=%0d", i, ov2, $signed(s2), ws[i]);
      else n_pass++;
      tick();
      n_total++; if (ov2 !== 1'b0) $display("FAIL c1_pulse_end[%0d] got=%b want=0", i, ov2); else n_pass++;
    end
  endtask

  // Random traffic on the 16-bit accumulator, where overflow is common.
  task automatic test_random();
    longint m_acc = 0;
    bit m_ovf = 1'b0;
    bit o;
    int m_n = 0;
    longint exp_s[$];
    bit exp_o[$];
    longint p, es;
    bit eo, drain;
    for (int cyc = 0; cyc < 500; cyc++) begin
      drain = (cyc >= 400);
      v1    = drain ? (m_n != 0) : ($urandom_range(0, 3) != 0);
      a1    = 8'($urandom);
      b1    = 8'($urandom);
      ordy1 = drain ? 1'b1 : ($urandom_range(0, 2) != 0);
      #1;
      if (ov1 && ordy1) begin
        n_total++;
        if (exp_s.size() == 0) $display("FAIL rand_unexpected got sum=%0d want no result", $signed(s1));
        else begin
          es = exp_s.pop_front(); eo = exp_o.pop_front();
          if (s1 !== 16'(es) || of1 !== eo)
            $display("FAIL rand_result got sum=%0d ovf=%b want sum=%0d ovf=%b", $signed(s1), of1, es, eo);
          else n_pass++;
        end
      end
      if (v1 && r1) begin
        p = longint'($signed(a1)) * longint'($signed(b1));
        if (m_n == 0) begin
          m_acc = p; m_ovf = 1'b0;
        end else begin
          m_acc = fit(m_acc + p, 16, o);
          m_ovf = m_ovf | o;
        end
        m_n++;
        if (m_n == 4) begin
          exp_s.push_back(m_acc); exp_o.push_back(m_ovf); m_n = 0;
        end
      end
      tick();
    end
    v1 = 1'b0;
    n_total++;
    if (exp_s.size() != 0 || m_n != 0)
      $display("FAIL rand_drain got pending=%0d partial=%0d want 0 0", exp_s.size(), m_n);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    v0 = 1'b0; a0 = '0; b0 = '0; ordy0 = 1'b0;
    v1 = 1'b0; a1 = '0; b1 = '0; ordy1 = 1'b0;
    v2 = 1'b0; a2 = '0; b2 = '0; ordy2 = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_gaps();
    test_reset_mid();
    test_overflow();
    test_count1();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
